// File: rtl/mod_74x161_chain.sv
// Cascade of 74x161 synchronous 4-bit counters forming a WIDTH-bit up-counter.
// Carry ripples combinationally from nibble to nibble through each stage's RCO/ENT.

module mod_74x161_nib (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load_n,
    input  logic       enp,
    input  logic       ent,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       rco
);
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            q <= '0;
        else if (!load_n)
            q <= d;
        else if (enp && ent)
            q <= q + 4'd1;
    end

    // RCO depends only on ENT and the stored count, never on ENP or LOAD_n.
    assign rco = ent && (q == 4'hF);
endmodule

module mod_74x161_chain #(
    parameter  int WIDTH = 8,
    localparam int NIB   = WIDTH / 4
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic [NIB-1:0]   RCO_NIB
);
    logic [NIB-1:0][3:0] q_nib;
    logic [NIB:0]        ent_chain;

    // Stage i is enabled by the carry of stage i-1; stage 0 takes ENT directly.
    assign ent_chain[0] = ENT;

    for (genvar i = 0; i < NIB; i++) begin : g_nib
        mod_74x161_nib u_nib (
            .clk    (CLK),
            .clr_n  (CLR_n),
            .load_n (LOAD_n),
            .enp    (ENP),
            .ent    (ent_chain[i]),
            .d      (D[4*i +: 4]),
            .q      (q_nib[i]),
            .rco    (ent_chain[i+1])
        );
    end

    assign Q       = q_nib;
    assign RCO_NIB = ent_chain[NIB:1];
    assign RCO     = ent_chain[NIB];
endmodule

// File: tb/tb_mod_74x161_chain.sv
// Self-checking bench for mod_74x161_chain: 8-bit and 16-bit instances share controls.
// Expected Q values are queued at stimulus time and popped after the clock edge.

module tb_mod_74x161_chain;
    logic        clk = 1'b0;
    logic        clr_n, load_n, enp, ent;
    logic [7:0]  d8, q8;
    logic        rco8;
    logic [1:0]  rn8;
    logic [15:0] d16, q16;
    logic        rco16;
    logic [3:0]  rn16;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_v;

    always #5 clk = ~clk;

    mod_74x161_chain #(.WIDTH(8)) dut8 (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent),
        .D(d8), .Q(q8), .RCO(rco8), .RCO_NIB(rn8)
    );

    mod_74x161_chain #(.WIDTH(16)) dut16 (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent),
        .D(d16), .Q(q16), .RCO(rco16), .RCO_NIB(rn16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] v);
        load_n = 1'b0; d8 = v;
        tick();
        load_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; load_n = 1'b0; enp = 1'b1; ent = 1'b1; d8 = 8'hFF; d16 = 16'hFFFF;
        #1;
        checks++;
        if (q8 !== 8'h00 || rco8 !== 1'b0 || rn8 !== 2'b00) begin
            errors++; $display("FAIL reset_init: q=%h rco=%b rn=%b, want 00/0/00", q8, rco8, rn8);
        end
        tick();
        checks++;
        if (q8 !== 8'h00 || q16 !== 16'h0000) begin
            errors++; $display("FAIL reset_priority: q8=%h q16=%h, want 0", q8, q16);
        end
        clr_n = 1'b1;
        load8(8'h50);
        enp = 1'b1; ent = 1'b1;
        repeat (10) tick();
        checks++;
        if (q8 !== 8'h5A) begin
            errors++; $display("FAIL count_to_5a: got %h want 5a", q8);
        end
        #2 clr_n = 1'b0;
        #1;
        checks++;
        if (q8 !== 8'h00 || rco8 !== 1'b0) begin
            errors++; $display("FAIL async_clear: q=%h rco=%b, want 00/0", q8, rco8);
        end
        tick();
        clr_n = 1'b1;
        load_n = 1'b0; d8 = 8'h12;
        sb.push_back(16'h0012);
        tick();
        load_n = 1'b1;
        exp_v = sb.pop_front();
        checks++;
        if (q8 !== exp_v[7:0]) begin
            errors++; $display("FAIL first_edge_after_clear: got %h want %h", q8, exp_v[7:0]);
        end
    endtask

    task automatic test_carry();
        enp = 1'b0; ent = 1'b0;
        load8(8'h0E);
        enp = 1'b1; ent = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(16'h000F + 16'(i));
            tick();
            exp_v = sb.pop_front();
            checks++;
            if (q8 !== exp_v[7:0] || rn8[0] !== (exp_v[7:0] == 8'h0F)) begin
                errors++; $display("FAIL carry_step%0d: q=%h rn0=%b want q=%h rn0=%b",
                                   i, q8, rn8[0], exp_v[7:0], exp_v[7:0] == 8'h0F);
            end
        end
    endtask

    task automatic test_wrap();
        enp = 1'b0; ent = 1'b0;
        load8(8'hFF);
        ent = 1'b1;
        #1;
        checks++;
        if (rco8 !== 1'b1 || rn8 !== 2'b11) begin
            errors++; $display("FAIL wrap_rco_before: rco=%b rn=%b want 1/11", rco8, rn8);
        end
        enp = 1'b1;
        sb.push_back(16'h0000);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (q8 !== exp_v[7:0] || rco8 !== 1'b0) begin
            errors++; $display("FAIL wrap_after: q=%h rco=%b want %h/0", q8, rco8, exp_v[7:0]);
        end
    endtask

    task automatic test_enable_gating();
        enp = 1'b0; ent = 1'b0;
        load8(8'hFF);
        ent = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(16'h00FF);
            tick();
            exp_v = sb.pop_front();
            checks++;
            if (q8 !== exp_v[7:0] || rco8 !== 1'b1) begin
                errors++; $display("FAIL enp_hold%0d: q=%h rco=%b want %h/1", i, q8, rco8, exp_v[7:0]);
            end
        end
        ent = 1'b0;
        #1;
        checks++;
        if (rco8 !== 1'b0 || rn8 !== 2'b00) begin
            errors++; $display("FAIL ent_drop_rco: rco=%b rn=%b want 0/00", rco8, rn8);
        end
        enp = 1'b1;
        sb.push_back(16'h00FF);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (q8 !== exp_v[7:0]) begin
            errors++; $display("FAIL ent_hold: got %h want %h", q8, exp_v[7:0]);
        end
    endtask

    task automatic test_load_priority();
        enp = 1'b0; ent = 1'b0;
        load8(8'h33);
        enp = 1'b1; ent = 1'b1; load_n = 1'b0; d8 = 8'hA7;
        sb.push_back(16'h00A7);
        tick();
        load_n = 1'b1;
        exp_v = sb.pop_front();
        checks++;
        if (q8 !== exp_v[7:0]) begin
            errors++; $display("FAIL load_priority: got %h want %h", q8, exp_v[7:0]);
        end
    endtask

    task automatic test_width16();
        enp = 1'b0; ent = 1'b0;
        load_n = 1'b0; d16 = 16'h0FFF;
        tick();
        load_n = 1'b1; enp = 1'b1; ent = 1'b1;
        #1;
        checks++;
        if (rn16 !== 4'b0111 || rco16 !== 1'b0) begin
            errors++; $display("FAIL w16_rn_before: rn=%b rco=%b want 0111/0", rn16, rco16);
        end
        sb.push_back(16'h1000);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (q16 !== exp_v || rn16 !== 4'b0000) begin
            errors++; $display("FAIL w16_after: q=%h rn=%b want %h/0000", q16, rn16, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  m8;
        logic [15:0] m16;
        enp = 1'b0; ent = 1'b0;
        load_n = 1'b0; d8 = 8'hF8; d16 = 16'hFFF6;
        tick();
        m8 = 8'hF8; m16 = 16'hFFF6;
        for (int i = 0; i < 60; i++) begin
            load_n = ($urandom_range(0, 9) != 0);
            enp    = ($urandom_range(0, 4) != 0);
            ent    = ($urandom_range(0, 4) != 0);
            d8     = 8'($urandom);
            d16    = 16'($urandom);
            #1;
            checks++;
            if (rco8 !== (ent && m8 == 8'hFF) || rco16 !== (ent && m16 == 16'hFFFF)) begin
                errors++; $display("FAIL b2b_rco%0d: rco8=%b rco16=%b m8=%h m16=%h ent=%b",
                                   i, rco8, rco16, m8, m16, ent);
            end
            if (!load_n) begin
                m8 = d8; m16 = d16;
            end else if (enp && ent) begin
                m8 = m8 + 8'd1; m16 = m16 + 16'd1;
            end
            sb.push_back({8'h00, m8});
            sb.push_back(m16);
            tick();
            exp_v = sb.pop_front();
            checks++;
            if (q8 !== exp_v[7:0]) begin
                errors++; $display("FAIL b2b_q8_%0d: got %h want %h", i, q8, exp_v[7:0]);
            end
            exp_v = sb.pop_front();
            checks++;
            if (q16 !== exp_v) begin
                errors++; $display("FAIL b2b_q16_%0d: got %h want %h", i, q16, exp_v);
            end
        end
        load_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap();
        test_enable_gating();
        test_load_priority();
        test_width16();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod_74x161_chain.md
MOD_74X161_CHAIN -- requirements
Module: mod_74x161_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits; legal values are multiples of 4 with WIDTH >= 4.
REQ-002 SHALL have parameter NIB, derived as WIDTH/4, the number of cascaded 74x161 nibble stages; it is not user-overridable.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port CLR_n, input, 1, the reset; asynchronous, active-low; clears all state.
REQ-005 SHALL have port LOAD_n, input, 1, synchronous parallel load, active-low.
REQ-006 SHALL have port ENP, input, 1, count-enable P; gates counting only.
REQ-007 SHALL have port ENT, input, 1, count-enable T; gates counting and RCO.
REQ-008 SHALL have port D, input, WIDTH, parallel load data; D[3:0] feeds nibble 0.
REQ-009 SHALL have port Q, output, WIDTH, registered count; Q[4i+3:4i] is nibble i.
REQ-010 SHALL have port RCO, output, 1, ripple-carry out of the top nibble.
REQ-011 SHALL have port RCO_NIB, output, NIB, per-nibble ripple-carry outputs, exposed for cascade observation.

Function
REQ-012 SHALL model NIB 74x161 stages, with ENT_0 = ENT and ENT_i = RCO_NIB[i-1] for i >= 1.
REQ-013 SHALL compute each RCO_NIB[i] combinationally as ENT_i AND (nibble i == 4'hF), independent of ENP, LOAD_n and CLK.
REQ-014 SHALL drive RCO as RCO_NIB[NIB-1].
REQ-015 SHALL, on a rising CLK edge with CLR_n high and LOAD_n low, load Q <= D in every nibble, regardless of ENP and ENT.
REQ-016 SHALL, on a rising CLK edge with CLR_n high, LOAD_n high and ENP high, increment nibble i modulo 16 exactly when ENT_i is high, using ENT_i values sampled before the edge.
REQ-017 SHALL, on a rising CLK edge with LOAD_n high and ENP low, hold every nibble.
REQ-018 SHALL, on a rising CLK edge with LOAD_n high and ENT low, hold every nibble.
REQ-019 SHALL have a net effect of a WIDTH-bit binary up-counter with 1-cycle latency from enable to the Q update.
REQ-020 SHALL wrap Q from all-ones to all-zeros with no extra cycle and no sticky flag.
REQ-021 SHALL let load take priority over counting when both LOAD_n is low and the count condition holds.
REQ-022 SHALL let CLR_n low take priority over everything else, coincident CLK edge included.
REQ-023 SHALL pass an ENT change through to RCO and to all cascaded RCO_NIB in the same cycle, with no register in the carry chain.
REQ-024 SHALL use no internal state other than Q; no hidden pipeline, no state machine beyond the per-nibble counters.

Reset
REQ-025 SHALL, while CLR_n is low, force Q = 0 immediately (asynchronous, no CLK needed); RCO and RCO_NIB therefore read 0.
REQ-026 SHALL, on CLR_n asserted mid-count or mid-load, abort the operation and clear Q in the same instant; no partial update may survive.
REQ-027 SHALL take effect on the first rising CLK edge after CLR_n deasserts, with no dead cycle; deassertion is assumed synchronous to CLK by the system.

Verification
REQ-028 SHALL pass this reset scenario: WIDTH=8, count to 0x5A, pull CLR_n low between edges -> Q = 0x00 before the next edge; RCO = 0.
REQ-029 SHALL pass this carry-across-nibbles scenario: load 0x0E, then ENP=ENT=1 for 3 edges -> Q = 0x0F, then 0x10, then 0x11; RCO_NIB[0] = 1 only while Q = 0x0F.
REQ-030 SHALL pass this wrap scenario: load 0xFF, ENT=1 -> RCO = 1 before the edge; one counting edge -> Q = 0x00, RCO = 0.
REQ-031 SHALL pass this enable-gating scenario: Q = 0xFF, ENT=1, ENP=0 -> RCO = 1 and Q holds 0xFF across 4 edges; then ENT=0 -> RCO = 0 immediately.
REQ-032 SHALL pass this load-priority scenario: Q = 0x33, ENP=ENT=1, LOAD_n=0, D = 0xA7 -> next edge Q = 0xA7, not 0x34.
REQ-033 SHALL pass this WIDTH=16 scenario: load 0x0FFF, one counting edge -> Q = 0x1000; RCO_NIB = 4'b0111 before the edge and 4'b0000 after.
